// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT timer: register offsets, response codes,
// FSM state types and small decode/merge helpers.
package clint_pkg;

  localparam logic [3:0] OFF_MTIME_LO    = 4'h0;
  localparam logic [3:0] OFF_MTIME_HI    = 4'h4;
  localparam logic [3:0] OFF_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] OFF_MTIMECMP_HI = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_RESP
  } rd_state_e;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_e;

  // Offset is relative to BASE_ADDR; only the four aligned words of the window decode.
  function automatic logic offsetValid(input logic [31:0] off);
    return (off[31:4] == 28'd0) && (off[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = oldVal;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = newVal[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Read/write request-response bus of the CLINT timer plus its interrupt line.
interface clint_timer_if;
  logic        io_ar_valid;
  logic        io_ar_ready;
  logic [31:0] io_araddr;
  logic        io_r_valid;
  logic        io_r_ready;
  logic [31:0] io_rdata;
  logic [1:0]  io_rresp;
  logic        io_w_valid;
  logic        io_w_ready;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        io_b_valid;
  logic        io_b_ready;
  logic [1:0]  io_bresp;
  logic        io_mtip;

  modport slave (
    input  io_ar_valid, io_araddr, io_r_ready,
    input  io_w_valid, io_waddr, io_wdata, io_wstrb, io_b_ready,
    output io_ar_ready, io_r_valid, io_rdata, io_rresp,
    output io_w_ready, io_b_valid, io_bresp, io_mtip
  );

  modport master (
    output io_ar_valid, io_araddr, io_r_ready,
    output io_w_valid, io_waddr, io_wdata, io_wstrb, io_b_ready,
    input  io_ar_ready, io_r_valid, io_rdata, io_rresp,
    input  io_w_ready, io_b_valid, io_bresp, io_mtip
  );
endinterface

// File: rtl/clint_lfsr.sv
// 16-bit maximal-length Fibonacci LFSR (taps 16,14,13,11), stepping every cycle;
// the low three bits feed the random read latency.
module clint_lfsr (
  input  logic       clock,
  input  logic       reset,
  output logic [2:0] rnd
);
  logic [15:0] state;
  logic        feedback;

  assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= 16'h0001;
    else        state <= {state[14:0], feedback};
  end

  assign rnd = state[2:0];
endmodule

// File: rtl/clint_timer.sv
// RISC-V style machine timer: prescaled 64-bit mtime, mtimecmp and a registered
// mtip, exposed through a small request/response register bus.
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'ha0000048,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned DELAY_MODE  = 0,
  parameter int unsigned FIXED_DELAY = 2
) (
  input logic         clock,
  input logic         reset,
  clint_timer_if.slave bus
);
  logic [15:0] prescaleCnt;
  logic        tick;
  logic [63:0] mtime, mtimecmp, mtimeInc, mtimeNext, mtimecmpNext;
  logic        mtip;
  rd_state_e   rdState, rdStateNext;
  wr_state_e   wrState, wrStateNext;
  logic [2:0]  delayCnt, delayCntNext, delayLoad, lfsrBits;
  logic [31:0] rdataQ, rdataNext, rdOff, wrOff, rdWord;
  logic [1:0]  rrespQ, rrespNext, brespQ, brespNext;
  logic        rdValid, wrValid, wFire;

  if (DELAY_MODE == 1) begin : gLfsr
    clint_lfsr uLfsr (.clock(clock), .reset(reset), .rnd(lfsrBits));
  end else begin : gNoLfsr
    assign lfsrBits = '0;
  end

  assign delayLoad = (DELAY_MODE == 1) ? lfsrBits : 3'(FIXED_DELAY);
  assign tick      = (prescaleCnt == 16'(PRESCALE - 1));
  assign rdOff     = bus.io_araddr - BASE_ADDR;
  assign wrOff     = bus.io_waddr - BASE_ADDR;
  assign rdValid   = offsetValid(rdOff);
  assign wrValid   = offsetValid(wrOff);
  assign wFire     = (wrState == WR_IDLE) && bus.io_w_valid;

  always_comb begin
    unique case (rdOff[3:0])
      OFF_MTIME_LO:    rdWord = mtime[31:0];
      OFF_MTIME_HI:    rdWord = mtime[63:32];
      OFF_MTIMECMP_LO: rdWord = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rdWord = mtimecmp[63:32];
      default:         rdWord = '0;
    endcase
  end

  // Write bytes are merged over the already-incremented mtime so a coincident tick is kept.
  always_comb begin
    mtimeInc     = mtime + {63'd0, tick};
    mtimeNext    = mtimeInc;
    mtimecmpNext = mtimecmp;
    if (wFire && wrValid) begin
      unique case (wrOff[3:0])
        OFF_MTIME_LO:    mtimeNext[31:0]     = mergeBytes(mtimeInc[31:0], bus.io_wdata, bus.io_wstrb);
        OFF_MTIME_HI:    mtimeNext[63:32]    = mergeBytes(mtimeInc[63:32], bus.io_wdata, bus.io_wstrb);
        OFF_MTIMECMP_LO: mtimecmpNext[31:0]  = mergeBytes(mtimecmp[31:0], bus.io_wdata, bus.io_wstrb);
        OFF_MTIMECMP_HI: mtimecmpNext[63:32] = mergeBytes(mtimecmp[63:32], bus.io_wdata, bus.io_wstrb);
        default: ;
      endcase
    end
  end

  // A zero delay bypasses WAIT so the response appears one cycle after the handshake.
  always_comb begin
    rdStateNext  = rdState;
    delayCntNext = delayCnt;
    rdataNext    = rdataQ;
    rrespNext    = rrespQ;
    unique case (rdState)
      RD_IDLE: if (bus.io_ar_valid) begin
        rdataNext    = rdValid ? rdWord : '0;
        rrespNext    = rdValid ? RESP_OKAY : RESP_SLVERR;
        delayCntNext = delayLoad;
        rdStateNext  = (delayLoad == 3'd0) ? RD_RESP : RD_WAIT;
      end
      RD_WAIT: begin
        delayCntNext = delayCnt - 3'd1;
        if (delayCnt == 3'd1) rdStateNext = RD_RESP;
      end
      RD_RESP: if (bus.io_r_ready) rdStateNext = RD_IDLE;
      default: rdStateNext = RD_IDLE;
    endcase
  end

  always_comb begin
    wrStateNext = wrState;
    brespNext   = brespQ;
    unique case (wrState)
      WR_IDLE: if (bus.io_w_valid) begin
        wrStateNext = WR_RESP;
        brespNext   = wrValid ? RESP_OKAY : RESP_SLVERR;
      end
      WR_RESP: if (bus.io_b_ready) wrStateNext = WR_IDLE;
      default: wrStateNext = WR_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaleCnt <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      mtip        <= 1'b0;
      rdState     <= RD_IDLE;
      wrState     <= WR_IDLE;
      delayCnt    <= '0;
      rdataQ      <= '0;
      rrespQ      <= RESP_OKAY;
      brespQ      <= RESP_OKAY;
    end else begin
      prescaleCnt <= tick ? '0 : prescaleCnt + 16'd1;
      mtime       <= mtimeNext;
      mtimecmp    <= mtimecmpNext;
      mtip        <= (mtime >= mtimecmp);
      rdState     <= rdStateNext;
      wrState     <= wrStateNext;
      delayCnt    <= delayCntNext;
      rdataQ      <= rdataNext;
      rrespQ      <= rrespNext;
      brespQ      <= brespNext;
    end
  end

  assign bus.io_ar_ready = (rdState == RD_IDLE);
  assign bus.io_r_valid  = (rdState == RD_RESP);
  assign bus.io_rdata    = rdataQ;
  assign bus.io_rresp    = rrespQ;
  assign bus.io_w_ready  = (wrState == WR_IDLE);
  assign bus.io_b_valid  = (wrState == WR_RESP);
  assign bus.io_bresp    = brespQ;
  assign bus.io_mtip     = mtip;
endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: dutA (PRESCALE=4, fixed delay 2) and
// dutB (PRESCALE=1, LFSR delay) share stimulus, selected by sel.
module tb_clint_timer;
  import clint_pkg::*;

  localparam logic [31:0] BASE = 32'ha0000048;

  typedef struct {
    bit          isWr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expData;
    logic [1:0]  expResp;
  } vec_t;

  logic clock = 1'b0;
  logic rstN  = 1'b1;
  logic sel   = 1'b0;
  logic arValid = 1'b0, rReady = 1'b0, wValid = 1'b0, bReady = 1'b0;
  logic [31:0] arAddr = '0, wAddr = '0, wData = '0;
  logic [3:0]  wStrb = '0;
  logic arReady, rValid, wReady, bValid, mtipA, mtipB;
  logic [31:0] rData;
  logic [1:0]  rResp, bResp;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  clint_timer_if ifA();
  clint_timer_if ifB();

  assign ifA.io_ar_valid = arValid & ~sel;
  assign ifB.io_ar_valid = arValid & sel;
  assign ifA.io_w_valid  = wValid & ~sel;
  assign ifB.io_w_valid  = wValid & sel;
  assign ifA.io_araddr = arAddr;  assign ifB.io_araddr = arAddr;
  assign ifA.io_r_ready = rReady; assign ifB.io_r_ready = rReady;
  assign ifA.io_waddr = wAddr;    assign ifB.io_waddr = wAddr;
  assign ifA.io_wdata = wData;    assign ifB.io_wdata = wData;
  assign ifA.io_wstrb = wStrb;    assign ifB.io_wstrb = wStrb;
  assign ifA.io_b_ready = bReady; assign ifB.io_b_ready = bReady;

  assign arReady = sel ? ifB.io_ar_ready : ifA.io_ar_ready;
  assign rValid  = sel ? ifB.io_r_valid  : ifA.io_r_valid;
  assign rData   = sel ? ifB.io_rdata    : ifA.io_rdata;
  assign rResp   = sel ? ifB.io_rresp    : ifA.io_rresp;
  assign wReady  = sel ? ifB.io_w_ready  : ifA.io_w_ready;
  assign bValid  = sel ? ifB.io_b_valid  : ifA.io_b_valid;
  assign bResp   = sel ? ifB.io_bresp    : ifA.io_bresp;
  assign mtipA   = ifA.io_mtip;
  assign mtipB   = ifB.io_mtip;

  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(4), .DELAY_MODE(0), .FIXED_DELAY(2))
    dutA (.clock(clock), .reset(rstN), .bus(ifA));
  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(1), .DELAY_MODE(1), .FIXED_DELAY(0))
    dutB (.clock(clock), .reset(rstN), .bus(ifB));

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chkRange(input string name, input int unsigned act, input int unsigned lo,
                          input int unsigned hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Called just after a negedge; hsEdge is the index of the handshake clock edge.
  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         output logic [1:0] resp, output int unsigned hsEdge, output bit ok);
    int unsigned n = 0;
    wValid = 1'b1; wAddr = addr; wData = data; wStrb = strb;
    while (!wReady && n < 20) begin @(negedge clock); n++; end
    hsEdge = cyc + 1;
    @(negedge clock);
    wValid = 1'b0;
    n = 0;
    while (!bValid && n < 20) begin @(negedge clock); n++; end
    ok = bValid;
    resp = bResp;
    bReady = 1'b1;
    @(negedge clock);
    bReady = 1'b0;
  endtask

  // Leaves the response pending; lat counts cycles from handshake cycle to first r_valid.
  task automatic doRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                        output int unsigned lat, output int unsigned hsEdge, output bit ok);
    int unsigned n = 0;
    int unsigned c0;
    arValid = 1'b1; arAddr = addr;
    while (!arReady && n < 20) begin @(negedge clock); n++; end
    c0 = cyc;
    hsEdge = c0 + 1;
    @(negedge clock);
    arValid = 1'b0;
    n = 0;
    while (!rValid && n < 20) begin @(negedge clock); n++; end
    lat = cyc - c0;
    ok = rValid;
    data = rData;
    resp = rResp;
  endtask

  task automatic rdAccept();
    rReady = 1'b1;
    @(negedge clock);
    rReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[14];
    logic [31:0] d, expD;
    logic [1:0]  r;
    int unsigned lat, hs, hs2, rel;
    bit ok, found, seen;
    logic [8:0] seenLat;

    vecs[0]  = '{1'b1, BASE + 32'h8,  32'h1122_3344, 4'hF,    32'h0,         RESP_OKAY};
    vecs[1]  = '{1'b0, BASE + 32'h8,  32'h0,         4'h0,    32'h1122_3344, RESP_OKAY};
    vecs[2]  = '{1'b1, BASE + 32'hC,  32'hDEAD_BEEF, 4'b0101, 32'h0,         RESP_OKAY};
    vecs[3]  = '{1'b0, BASE + 32'hC,  32'h0,         4'h0,    32'hFFAD_FFEF, RESP_OKAY};
    vecs[4]  = '{1'b1, BASE + 32'h8,  32'hAABB_CCDD, 4'b1000, 32'h0,         RESP_OKAY};
    vecs[5]  = '{1'b0, BASE + 32'h8,  32'h0,         4'h0,    32'hAA22_3344, RESP_OKAY};
    vecs[6]  = '{1'b0, BASE + 32'h10, 32'h0,         4'h0,    32'h0,         RESP_SLVERR};
    vecs[7]  = '{1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF,    32'h0,         RESP_SLVERR};
    vecs[8]  = '{1'b0, BASE + 32'h8,  32'h0,         4'h0,    32'hAA22_3344, RESP_OKAY};
    vecs[9]  = '{1'b0, BASE + 32'hC,  32'h0,         4'h0,    32'hFFAD_FFEF, RESP_OKAY};
    vecs[10] = '{1'b0, BASE + 32'h2,  32'h0,         4'h0,    32'h0,         RESP_SLVERR};
    vecs[11] = '{1'b0, BASE - 32'h4,  32'h0,         4'h0,    32'h0,         RESP_SLVERR};
    vecs[12] = '{1'b1, BASE + 32'h4,  32'h0000_0005, 4'b0001, 32'h0,         RESP_OKAY};
    vecs[13] = '{1'b0, BASE + 32'h4,  32'h0,         4'h0,    32'h0000_0005, RESP_OKAY};

    // Asynchronous reset: outputs must settle before any clock edge.
    #2 rstN = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      chk1($sformatf("rst_ar_ready%0d", s), arReady, 1'b1);
      chk1($sformatf("rst_w_ready%0d", s), wReady, 1'b1);
      chk1($sformatf("rst_r_valid%0d", s), rValid, 1'b0);
      chk1($sformatf("rst_b_valid%0d", s), bValid, 1'b0);
      chk32($sformatf("rst_rdata%0d", s), rData, 32'h0);
      chk32($sformatf("rst_rresp%0d", s), {30'd0, rResp}, 32'h0);
      chk32($sformatf("rst_bresp%0d", s), {30'd0, bResp}, 32'h0);
    end
    chk1("rst_mtipA", mtipA, 1'b0);
    chk1("rst_mtipB", mtipB, 1'b0);
    sel = 1'b0;
    repeat (3) @(negedge clock);
    rstN = 1'b1;
    rel = cyc;

    // 40 idle cycles at PRESCALE=4 -> mtime reads 10.
    repeat (40) @(negedge clock);
    doRead(BASE, d, r, lat, hs, ok);
    chk1("idle40_ok", ok, 1'b1);
    chk32("idle40_mtime", d, 32'd10);
    chk1("idle40_mtip", mtipA, 1'b0);
    rdAccept();

    // Fixed delay 2: r_valid 3 cycles after handshake, held stable while r_ready low.
    doRead(BASE, d, r, lat, hs, ok);
    expD = (hs - rel - 1) / 4;
    chkRange("fixed_latency", lat, 3, 3);
    chk32("fixed_data", d, expD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk1($sformatf("hold_valid%0d", i), rValid, 1'b1);
      chk32($sformatf("hold_data%0d", i), rData, expD);
    end
    rdAccept();
    chk1("r_valid_dropped", rValid, 1'b0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].isWr) begin
        doWrite(vecs[i].addr, vecs[i].data, vecs[i].strb, r, hs, ok);
        chk1($sformatf("vec%0d_b_ok", i), ok, 1'b1);
        chk32($sformatf("vec%0d_bresp", i), {30'd0, r}, {30'd0, vecs[i].expResp});
      end else begin
        doRead(vecs[i].addr, d, r, lat, hs, ok);
        chk1($sformatf("vec%0d_r_ok", i), ok, 1'b1);
        chkRange($sformatf("vec%0d_lat", i), lat, 3, 3);
        chk32($sformatf("vec%0d_rdata", i), d, vecs[i].expData);
        chk32($sformatf("vec%0d_rresp", i), {30'd0, r}, {30'd0, vecs[i].expResp});
        rdAccept();
      end
    end
    chk1("vec_mtipA", mtipA, 1'b0);

    // Partial-strobe write to mtime low; unwritten bytes keep the running count.
    doWrite(BASE, 32'h1234_5678, 4'hF, r, hs, ok);
    chk32("mtime_set_bresp", {30'd0, r}, 32'h0);
    doWrite(BASE, 32'hAAAA_BBBB, 4'b0011, r, hs2, ok);
    chk32("mtime_strb_bresp", {30'd0, r}, 32'h0);
    doRead(BASE, d, r, lat, hs, ok);
    expD = 32'h1234_BBBB + ((hs - rel - 1) / 4 - (hs2 - rel) / 4);
    chk32("mtime_strb_merge", d, expD);
    rdAccept();

    // dutB, PRESCALE=1: mtip rises one cycle after mtime reaches mtimecmp=20.
    sel = 1'b1;
    doWrite(BASE, 32'h0, 4'hF, r, hs, ok);
    chk32("b_mtime_bresp", {30'd0, r}, 32'h0);
    doWrite(BASE + 32'h8, 32'd20, 4'hF, r, hs2, ok);
    chk32("b_cmplo_bresp", {30'd0, r}, 32'h0);
    doWrite(BASE + 32'hC, 32'd0, 4'hF, r, hs2, ok);
    chk32("b_cmphi_bresp", {30'd0, r}, 32'h0);
    chk1("b_mtip_early", mtipB, 1'b0);
    while (cyc < hs + 20) @(negedge clock);
    chk1("b_mtip_at20", mtipB, 1'b0);
    @(negedge clock);
    chk1("b_mtip_after20", mtipB, 1'b1);

    // Random latency: always 1..8 and not constant.
    seenLat = '0;
    for (int i = 0; i < 100; i++) begin
      doRead(BASE + 32'h8, d, r, lat, hs, ok);
      chk1($sformatf("rand%0d_ok", i), ok, 1'b1);
      chkRange($sformatf("rand%0d_lat", i), lat, 1, 8);
      if (lat <= 8) seenLat[lat] = 1'b1;
      rdAccept();
    end
    chk1("rand_distinct", ($countones(seenLat) > 1), 1'b1);

    // Reset while a read waits: the pending response must never appear.
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      arValid = 1'b1; arAddr = BASE;
      @(negedge clock);
      arValid = 1'b0;
      if (!rValid) begin
        found = 1'b1;
        rstN = 1'b0;
        #1;
        chk1("wait_rst_ar_ready", arReady, 1'b1);
        chk1("wait_rst_r_valid", rValid, 1'b0);
        @(negedge clock);
        @(negedge clock);
        rstN = 1'b1;
        seen = 1'b0;
        repeat (15) begin
          @(negedge clock);
          if (rValid) seen = 1'b1;
        end
        chk1("no_r_valid_after_reset", seen, 1'b0);
      end else begin
        rdAccept();
      end
    end
    chk1("wait_state_reached", found, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
